operand_capture: RTL and testbench
==================================

// Module: operand_capture
// PURPOSE
//  Parametrised operand-entry front end for the calculator datapath.
//  Captures NUM_OPS signed operands in sequence from the switch bank, with an
//  optional sign switch, and drives a live display value.
//  Edge-detects confirm and the display-mode button internally, so raw
//  synchronised button levels may be connected directly.
//  Sits between the input synchronisers and the ALU/display blocks.
// PARAMETERS
//  IN_W     4  width of unsigned magnitude input from switches
//  OP_W     6  width of each signed operand; must satisfy OP_W >= IN_W+1
//  NUM_OPS  2  number of operands captured per sequence (1..8)
// PORTS
//  clk                    in   1              system clock, rising edge
//  reset                  in   1              async, active-high
//  start                  in   1              level; begin a capture sequence
//  clear                  in   1              level; zero operands, return to IDLE
//  confirm                in   1              level; rising edge commits current operand
//  display_mode_change    in   1              level; rising edge toggles display_mode
//  sign_sw                in   1              1 = negate entered magnitude
//  operand_input          in   IN_W           unsigned magnitude
//  operands               out  NUM_OPS*OP_W   packed signed operands, op k at [k*OP_W +: OP_W]
//  operand_input_display  out  OP_W           signed live value being entered
//  op_index               out  3              index of operand currently being entered
//  busy                   out  1              1 while in ENTER
//  capture_done           out  1              1-cycle pulse when last operand committed
//  display_mode           out  1              toggled display format flag
// BEHAVIOUR
//  Reset (async): operands=0, display=0, op_index=0, busy=0, capture_done=0,
//    display_mode=0, edge-detect history=0, state=IDLE.
//  Value: val = sign_sw ? -zext(operand_input) : zext(operand_input), OP_W bits signed.
//    No overflow is possible given the OP_W constraint.
//    -0 encodes as 0.
//  Edge detect: confirm_re = confirm & ~confirm_q, where confirm_q is the
//    registered previous level. display_mode_change is handled identically.
//    A held level produces exactly one event.
//  display_mode: toggles on each rising edge in every state.
//  FSM states: IDLE, ENTER, DONE.
//   IDLE:  start=1 -> ENTER, op_index<=0. Operands are retained.
//   ENTER: operand_input_display<=val every cycle (1-cycle latency).
//          On confirm_re: operands[op_index]<=val.
//            If op_index==NUM_OPS-1: go to DONE; capture_done=1 next cycle.
//            Otherwise: op_index++.
//   DONE:  operands held. start=1 -> ENTER, op_index<=0.
//  Display: operand_input_display holds its last value outside ENTER.
//  busy: 1 only in ENTER.
//  Ignored events: confirm_re in IDLE/DONE (edge history still updates).
//  Priority, same cycle: clear > confirm_re > start.
//  clear, any state: operands=0, display=0, op_index=0, -> IDLE.
//    No capture_done is produced.
//  start in ENTER: ignored; the sequence is not restarted.
//  Reset mid-sequence: immediate return to the reset values above.
//  capture_done: never asserted two cycles in a row.
// TESTING
//  T1 defaults: start; in=5,sign=0, confirm; in=3,sign=1, confirm
//     -> operands[0]=5, operands[1]=-3 (6'sb111101),
//        capture_done pulses once, state DONE.
//  T2 held confirm: confirm high 10 cycles in ENTER
//     -> only operands[0] written, op_index=1.
//  T3 extremes: in=15,sign=1 -> -15 (6'sb110001); in=0,sign=1 -> 0.
//     Display tracks input with 1-cycle lag.
//  T4 priority: clear and confirm in same cycle
//     -> operands all 0, IDLE, no capture_done.
//     Confirm in IDLE -> no write.
//  T5 reset mid-entry after op0 committed
//     -> all outputs 0 asynchronously, IDLE.
//     display_mode toggles once per button press, also during reset release.
//  T6 NUM_OPS=4, OP_W=8, IN_W=4: four confirms
//     -> operands packed at correct offsets, op_index 0..3,
//        capture_done after the 4th confirm.

Source files
------------

// File: rtl/operand_capture.sv
// ---------------------------------------------------------------------------
// operand_capture
//
// Operand-entry front end for the calculator datapath. Collects NUM_OPS
// signed operands one after another from the switch bank, applying an
// optional sign switch, and presents the value currently being keyed in on
// a live display output. The confirm and display-mode buttons are
// edge-detected internally, so synchronised raw button levels can be wired
// straight in.
//
// Parameters
//   IN_W     width of the unsigned switch magnitude
//   OP_W     width of each signed operand (must be at least IN_W+1)
//   NUM_OPS  operands captured per sequence (1..8)
//
// Ports
//   clk                    system clock, rising edge
//   reset                  asynchronous, active-high
//   start                  level: begin a capture sequence (IDLE/DONE only)
//   clear                  level: zero operands and display, return to IDLE
//   confirm                level: rising edge commits the current operand
//   display_mode_change    level: rising edge toggles display_mode
//   sign_sw                1 = negate the entered magnitude
//   operand_input          unsigned magnitude from the switches
//   operands               packed operands, operand k at [k*OP_W +: OP_W]
//   operand_input_display  signed live value, one cycle behind the switches
//   op_index               index of the operand currently being entered
//   busy                   high while operands are being entered
//   capture_done           one-cycle pulse after the last operand commits
//   display_mode           display format flag
// ---------------------------------------------------------------------------
module operand_capture #(
    parameter int IN_W    = 4,
    parameter int OP_W    = 6,
    parameter int NUM_OPS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      confirm,
    input  logic                      display_mode_change,
    input  logic                      sign_sw,
    input  logic [IN_W-1:0]           operand_input,
    output logic [NUM_OPS*OP_W-1:0]   operands,
    output logic [OP_W-1:0]           operand_input_display,
    output logic [2:0]                op_index,
    output logic                      busy,
    output logic                      capture_done,
    output logic                      display_mode
);

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;

    logic            confirm_q;
    logic            mode_q;
    logic            confirm_re;
    logic            mode_re;

    logic [OP_W-1:0] magnitude;
    logic [OP_W-1:0] value;
    logic [OP_W-1:0] op_regs [NUM_OPS];

    logic            last_op;
    logic            enter_active;
    logic            commit;
    logic            commit_last;
    logic            begin_seq;

    // The magnitude is zero-extended before negation; because OP_W exceeds
    // IN_W the negated value always fits, and negating zero yields zero.
    assign magnitude  = {{(OP_W-IN_W){1'b0}}, operand_input};
    assign value      = sign_sw ? -magnitude : magnitude;

    assign confirm_re = confirm & ~confirm_q;
    assign mode_re    = display_mode_change & ~mode_q;
    assign last_op    = (op_index == 3'(NUM_OPS-1));

    // Button history: one register per button so a held level produces a
    // single event. History keeps updating in every state, so a press made
    // while idle is consumed and cannot fire later on entering ENTER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            confirm_q <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            confirm_q <= confirm;
            mode_q    <= display_mode_change;
        end
    end

    // Display format flag follows the mode button independently of the
    // capture sequence, including while clear is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_mode <= 1'b0;
        end else if (mode_re) begin
            display_mode <= ~display_mode;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Clear overrides everything; start is only honoured
    // outside ENTER so a running sequence is never restarted.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = ENTER;
                ENTER:   if (confirm_re && last_op) next_state = DONE;
                DONE:    if (start) next_state = ENTER;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output and control decode. The datapath strobes are qualified by
    // clear so that clear wins over a same-cycle confirm or start.
    always_comb begin
        busy         = (state == ENTER);
        enter_active = !clear && (state == ENTER);
        commit       = enter_active && confirm_re;
        commit_last  = commit && last_op;
        begin_seq    = !clear && start && ((state == IDLE) || (state == DONE));
    end

    // Operand storage, live display, operand index and completion pulse.
    // capture_done is registered from the final commit so it rises in the
    // same cycle the FSM reaches DONE, and it cannot repeat because DONE
    // never commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand_input_display <= '0;
            op_index              <= 3'd0;
            capture_done          <= 1'b0;
            for (int k = 0; k < NUM_OPS; k++) begin
                op_regs[k] <= '0;
            end
        end else begin
            capture_done <= commit_last;
            if (clear) begin
                operand_input_display <= '0;
                op_index              <= 3'd0;
                for (int k = 0; k < NUM_OPS; k++) begin
                    op_regs[k] <= '0;
                end
            end else begin
                if (enter_active) begin
                    operand_input_display <= value;
                end
                if (commit) begin
                    for (int k = 0; k < NUM_OPS; k++) begin
                        if (op_index == 3'(k)) begin
                            op_regs[k] <= value;
                        end
                    end
                    if (!last_op) begin
                        op_index <= op_index + 3'd1;
                    end
                end
                if (begin_seq) begin
                    op_index <= 3'd0;
                end
            end
        end
    end

    // Flatten the operand registers onto the packed output bus.
    always_comb begin
        operands = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            operands[k*OP_W +: OP_W] = op_regs[k];
        end
    end

endmodule

// File: tb/tb_operand_capture.sv
// ---------------------------------------------------------------------------
// tb_operand_capture
//
// Drives two instances of operand_capture from the same input stream: one
// with the default configuration (2 operands of 6 bits) and one with four
// 8-bit operands. A behavioural model tracks each instance in terms of
// "currently entering / not entering", an operand index and a list of
// signed integers. Every cycle the model's prediction is queued, and a
// separate monitor compares the DUT outputs against the queue after each
// clock edge. Completed captures are also queued separately and checked
// whenever a DUT raises capture_done.
// ---------------------------------------------------------------------------
module tb_operand_capture;

    logic        clk;
    logic        reset;
    logic        start;
    logic        clear;
    logic        confirm;
    logic        display_mode_change;
    logic        sign_sw;
    logic [3:0]  operand_input;

    logic [11:0] operands0;
    logic [5:0]  display0;
    logic [2:0]  op_index0;
    logic        busy0;
    logic        capture_done0;
    logic        display_mode0;

    logic [31:0] operands1;
    logic [7:0]  display1;
    logic [2:0]  op_index1;
    logic        busy1;
    logic        capture_done1;
    logic        display_mode1;

    int checks = 0;
    int errors = 0;

    operand_capture dut0 (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .clear                 (clear),
        .confirm               (confirm),
        .display_mode_change   (display_mode_change),
        .sign_sw               (sign_sw),
        .operand_input         (operand_input),
        .operands              (operands0),
        .operand_input_display (display0),
        .op_index              (op_index0),
        .busy                  (busy0),
        .capture_done          (capture_done0),
        .display_mode          (display_mode0)
    );

    operand_capture #(
        .IN_W    (4),
        .OP_W    (8),
        .NUM_OPS (4)
    ) dut1 (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .clear                 (clear),
        .confirm               (confirm),
        .display_mode_change   (display_mode_change),
        .sign_sw               (sign_sw),
        .operand_input         (operand_input),
        .operands              (operands1),
        .operand_input_display (display1),
        .op_index              (op_index1),
        .busy                  (busy1),
        .capture_done          (capture_done1),
        .display_mode          (display_mode1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [11:0] ops0;
        logic [5:0]  disp0;
        logic [2:0]  idx0;
        logic        busy0;
        logic        done0;
        logic [31:0] ops1;
        logic [7:0]  disp1;
        logic [2:0]  idx1;
        logic        busy1;
        logic        done1;
        logic        mode;
    } exp_t;

    exp_t        expq[$];
    logic [11:0] capq0[$];
    logic [31:0] capq1[$];

    // Reference model state
    bit m_active[2];
    int m_idx[2];
    int m_ops[2][8];
    int m_disp[2];
    bit m_done[2];
    bit m_mode;
    bit m_conf_prev;
    bit m_mode_prev;

    function automatic int nops(input int c);
        return (c == 0) ? 2 : 4;
    endfunction

    function automatic logic [11:0] pack0();
        logic [11:0] v;
        v = '0;
        for (int k = 0; k < 2; k++) v[k*6 +: 6] = 6'(m_ops[0][k]);
        return v;
    endfunction

    function automatic logic [31:0] pack1();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(m_ops[1][k]);
        return v;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            m_active[c] = 1'b0;
            m_idx[c]    = 0;
            m_disp[c]   = 0;
            m_done[c]   = 1'b0;
            for (int k = 0; k < 8; k++) m_ops[c][k] = 0;
        end
        m_mode      = 1'b0;
        m_conf_prev = 1'b0;
        m_mode_prev = 1'b0;
    endtask

    task automatic modelStep(input bit st, input bit cl, input bit cf,
                             input bit md, input bit sg, input int mag);
        bit conf_edge;
        bit mode_edge;
        int v;
        conf_edge = cf && !m_conf_prev;
        mode_edge = md && !m_mode_prev;
        v = sg ? -mag : mag;
        for (int c = 0; c < 2; c++) begin
            m_done[c] = 1'b0;
            if (cl) begin
                m_active[c] = 1'b0;
                m_idx[c]    = 0;
                m_disp[c]   = 0;
                for (int k = 0; k < 8; k++) m_ops[c][k] = 0;
            end else if (m_active[c]) begin
                m_disp[c] = v;
                if (conf_edge) begin
                    m_ops[c][m_idx[c]] = v;
                    if (m_idx[c] == nops(c) - 1) begin
                        m_active[c] = 1'b0;
                        m_done[c]   = 1'b1;
                        if (c == 0) capq0.push_back(pack0());
                        else        capq1.push_back(pack1());
                    end else begin
                        m_idx[c]++;
                    end
                end
            end else if (st) begin
                m_active[c] = 1'b1;
                m_idx[c]    = 0;
            end
        end
        if (mode_edge) m_mode = !m_mode;
        m_conf_prev = cf;
        m_mode_prev = md;
    endtask

    task automatic pushExpect();
        exp_t e;
        e.ops0  = pack0();
        e.disp0 = 6'(m_disp[0]);
        e.idx0  = 3'(m_idx[0]);
        e.busy0 = m_active[0];
        e.done0 = m_done[0];
        e.ops1  = pack1();
        e.disp1 = 8'(m_disp[1]);
        e.idx1  = 3'(m_idx[1]);
        e.busy1 = m_active[1];
        e.done1 = m_done[1];
        e.mode  = m_mode;
        expq.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the model's
    // prediction for the state after the next rising edge.
    task automatic applyStimulus(input bit st, input bit cl, input bit cf,
                                 input bit md, input bit sg, input int mag);
        @(negedge clk);
        reset               = 1'b0;
        start               = st;
        clear               = cl;
        confirm             = cf;
        display_mode_change = md;
        sign_sw             = sg;
        operand_input       = 4'(mag);
        modelStep(st, cl, cf, md, sg, mag);
        pushExpect();
    endtask

    // Assert reset mid-cycle and confirm the outputs drop without a clock.
    task automatic applyReset(input int cycles, input bit md);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset               = 1'b1;
            start               = 1'b0;
            clear               = 1'b0;
            confirm             = 1'b0;
            display_mode_change = md;
            sign_sw             = 1'b0;
            operand_input       = 4'd0;
            #1;
            checkOutput("async_ops0",  32'(operands0), 32'd0);
            checkOutput("async_ops1",  operands1,      32'd0);
            checkOutput("async_disp0", 32'(display0),  32'd0);
            checkOutput("async_idx1",  32'(op_index1), 32'd0);
            checkOutput("async_busy0", 32'(busy0),     32'd0);
            checkOutput("async_mode0", 32'(display_mode0), 32'd0);
            modelReset();
            pushExpect();
        end
    endtask

    // Monitor: compares every queued prediction after each rising edge and
    // checks completed captures against the capture queues.
    always @(posedge clk) begin
        exp_t e;
        logic [11:0] c0;
        logic [31:0] c1;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("operands0", 32'(operands0),     32'(e.ops0));
            checkOutput("display0",  32'(display0),      32'(e.disp0));
            checkOutput("op_index0", 32'(op_index0),     32'(e.idx0));
            checkOutput("busy0",     32'(busy0),         32'(e.busy0));
            checkOutput("cap_done0", 32'(capture_done0), 32'(e.done0));
            checkOutput("mode0",     32'(display_mode0), 32'(e.mode));
            checkOutput("operands1", operands1,          e.ops1);
            checkOutput("display1",  32'(display1),      32'(e.disp1));
            checkOutput("op_index1", 32'(op_index1),     32'(e.idx1));
            checkOutput("busy1",     32'(busy1),         32'(e.busy1));
            checkOutput("cap_done1", 32'(capture_done1), 32'(e.done1));
            checkOutput("mode1",     32'(display_mode1), 32'(e.mode));
        end
        if (capture_done0 === 1'b1) begin
            if (capq0.size() == 0) begin
                checkOutput("capture0_unexpected", 32'd1, 32'd0);
            end else begin
                c0 = capq0.pop_front();
                checkOutput("capture0_ops", 32'(operands0), 32'(c0));
            end
        end
        if (capture_done1 === 1'b1) begin
            if (capq1.size() == 0) begin
                checkOutput("capture1_unexpected", 32'd1, 32'd0);
            end else begin
                c1 = capq1.pop_front();
                checkOutput("capture1_ops", operands1, c1);
            end
        end
    end

    initial begin
        reset               = 1'b1;
        start               = 1'b0;
        clear               = 1'b0;
        confirm             = 1'b0;
        display_mode_change = 1'b0;
        sign_sw             = 1'b0;
        operand_input       = 4'd0;
        modelReset();
        applyReset(2, 1'b0);

        // Basic two-operand capture: 5 then -3
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 5);
        applyStimulus(0, 0, 1, 0, 0, 5);
        applyStimulus(0, 0, 0, 0, 1, 3);
        applyStimulus(0, 0, 1, 0, 1, 3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Confirm held for ten cycles gives a single commit
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 0, 7);
        applyStimulus(0, 0, 0, 0, 0, 7);

        // Extremes: -15 and negated zero; start while entering is ignored
        applyStimulus(0, 0, 0, 0, 1, 15);
        applyStimulus(1, 0, 1, 0, 1, 15);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 9);

        // Clear beats a same-cycle confirm; confirm in IDLE is ignored
        applyStimulus(0, 1, 1, 0, 0, 6);
        applyStimulus(0, 0, 0, 0, 0, 6);
        applyStimulus(0, 0, 1, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 0, 4);

        // Reset mid-entry after one commit, mode button held across release
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 11);
        applyStimulus(0, 0, 0, 0, 1, 2);
        applyReset(2, 1'b1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Four confirms, completing the wide instance
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 0, k[0], 3 + 4 * k);
            applyStimulus(0, 0, 0, 0, k[0], 3 + 4 * k);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset(1, $urandom_range(0, 1) == 0);
            end else begin
                applyStimulus($urandom_range(0, 99) < 10,
                              $urandom_range(0, 99) < 3,
                              $urandom_range(0, 99) < 45,
                              $urandom_range(0, 99) < 20,
                              $urandom_range(0, 1) == 1,
                              int'($urandom_range(0, 15)));
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        #3;
        checkOutput("expect_queue_drained", 32'(expq.size()),  32'd0);
        checkOutput("capture0_drained",     32'(capq0.size()), 32'd0);
        checkOutput("capture1_drained",     32'(capq1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
